// File: rtl/class_result_decoder_pkg.sv
// Shared class-tree definitions and defaults for the class result decoder.
`ifndef CLASS_DEFS_V
`define CLASS_DEFS_V
`define NUM_CLASSES 12
`define CLS_W 4
`define TREE_STAGES 4
`endif

package class_result_decoder_pkg;
    localparam int CLS_W          = `CLS_W;
    localparam int DEF_FIFO_DEPTH = 2;
    localparam int DEF_CNT_W      = 16;
endpackage

// File: rtl/class_result_fifo.sv
// Small result buffer; also exposes the head as it will be after this edge's pop.
module class_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   accept,
    output logic                   drop,
    output logic                   nxt_valid,
    output logic [WIDTH-1:0]       nxt_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_inc;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign accept    = push & (~full | do_pop);
    assign drop      = push & full & ~do_pop;
    assign rd_inc    = rd_ptr + 1'b1;
    assign nxt_valid = do_pop ? (count > CW'(1)) : ~empty;
    assign nxt_data  = do_pop ? mem[rd_inc] : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept && !clr) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_inc;
            count <= count + CW'(accept) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/class_result_decoder.sv
// Tags tree slots, captures the winning class, decodes and buffers it.
// Optional per-class histogram enabled by defining CLASS_HIST_EN.
module class_result_decoder
    import class_result_decoder_pkg::*;
#(
    parameter int NUM_CLASSES = `NUM_CLASSES,
    parameter int TREE_STAGES = `TREE_STAGES,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   in_valid,
    input  logic                   clr,
    input  logic [CLS_W-1:0]       q_num,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLS_W-1:0]       out_num,
    output logic [NUM_CLASSES-1:0] out_onehot,
    output logic                   err,
    output logic                   ovf,
    input  logic [CLS_W-1:0]       hist_sel,
    output logic [CNT_W-1:0]       hist_cnt
);
    localparam int W = CLS_W + NUM_CLASSES;

    logic [TREE_STAGES-1:0]       tag;
    logic                         cap_pend;
    logic [NUM_CLASSES-1:0]       q_onehot;
    logic                         q_legal;
    logic                         pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         fifo_accept;
    logic                         fifo_drop;
    logic                         nxt_valid;
    logic [W-1:0]                 nxt_data;
    logic                         unused_fifo;

    // cap_pend marks the cycle in which the tree output belongs to a tagged sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag      <= '0;
            cap_pend <= 1'b0;
        end else if (clr) begin
            tag      <= '0;
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= load & tag[TREE_STAGES-2];
            if (load) tag <= {tag[TREE_STAGES-2:0], in_valid};
        end
    end

    always_comb begin
        q_onehot = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            q_onehot[i] = (32'(q_num) == i + 1);
        end
        q_legal = |q_onehot;
    end

    assign pop = out_valid & out_ready;

    class_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (cap_pend),
        .pop       (pop),
        .wdata     ({q_num, q_onehot}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .accept    (fifo_accept),
        .drop      (fifo_drop),
        .nxt_valid (nxt_valid),
        .nxt_data  (nxt_data)
    );

    assign unused_fifo = ^{fifo_full, fifo_empty, fifo_count};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_num    <= '0;
            out_onehot <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else if (clr) begin
            out_valid  <= 1'b0;
            out_num    <= '0;
            out_onehot <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            out_valid <= nxt_valid;
            {out_num, out_onehot} <= nxt_valid ? nxt_data : '0;
            if (cap_pend && !q_legal) err <= 1'b1;
            if (fifo_drop) ovf <= 1'b1;
        end
    end

`ifdef CLASS_HIST_EN
    logic [CNT_W-1:0] cnt [NUM_CLASSES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            hist_cnt <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            hist_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (fifo_accept && q_onehot[i] && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            hist_cnt <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (32'(hist_sel) == i + 1) hist_cnt <= cnt[i];
            end
        end
    end
`else
    logic unused_hist;

    assign hist_cnt    = '0;
    assign unused_hist = ^{hist_sel, fifo_accept};
`endif
endmodule

// File: tb/tb_class_result_decoder.sv
// Directed self-checking bench for class_result_decoder.
module tb_class_result_decoder;
`ifdef CLASS_HIST_EN
    localparam int TB_CNT_W = 3;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load = 1'b0;
    logic                in_valid = 1'b0;
    logic                clr = 1'b0;
    logic [3:0]          q_num = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [3:0]          out_num;
    logic [11:0]         out_onehot;
    logic                err;
    logic                ovf;
    logic [3:0]          hist_sel = '0;
    logic [TB_CNT_W-1:0] hist_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    class_result_decoder #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .in_valid   (in_valid),
        .clr        (clr),
        .q_num      (q_num),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_num    (out_num),
        .out_onehot (out_onehot),
        .err        (err),
        .ovf        (ovf),
        .hist_sel   (hist_sel),
        .hist_cnt   (hist_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 6; i++) begin
            load = i[0];
            in_valid = 1'b1;
            q_num = 4'd7;
            tick();
            total++;
            if ({out_valid, out_num, out_onehot, err, ovf} !== 19'd0 || hist_cnt !== '0) begin
                bad++;
                $display("FAIL reset: got v=%0b n=%0h oh=%0h e=%0b o=%0b h=%0h want all 0",
                         out_valid, out_num, out_onehot, err, ovf, hist_cnt);
            end
        end
        load = 1'b0;
        in_valid = 1'b0;
        q_num = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        out_ready = 1'b0;
        load = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        q_num = 4'd7;
        tick();
        load = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: got v=%0b want 0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_num !== 4'd7 || out_onehot !== 12'h040) begin
            bad++;
            $display("FAIL single: got v=%0b n=%0d oh=%0h want v=1 n=7 oh=040",
                     out_valid, out_num, out_onehot);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_num !== 4'd7) begin
            bad++;
            $display("FAIL single_hold: got v=%0b n=%0d want v=1 n=7", out_valid, out_num);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pop: got v=%0b want 0", out_valid);
        end
        q_num = '0;
    endtask

    task automatic test_stream;
        logic [11:0] oh;
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            load = (c <= 10);
            in_valid = (c < 8);
            q_num = (c >= 4 && c <= 11) ? 4'(c - 3) : 4'd0;
            tick();
            total++;
            if (c >= 5 && c <= 12) begin
                oh = 12'h001 << (c - 5);
                if (out_valid !== 1'b1 || out_num !== 4'(c - 4) || out_onehot !== oh) begin
                    bad++;
                    $display("FAIL stream c=%0d: got v=%0b n=%0d oh=%0h want v=1 n=%0d oh=%0h",
                             c, out_valid, out_num, out_onehot, c - 4, oh);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stream_idle c=%0d: got v=%0b want 0", c, out_valid);
            end
        end
        load = 1'b0;
        in_valid = 1'b0;
        q_num = '0;
    endtask

    task automatic test_gaps;
        logic exp_v;
        out_ready = 1'b1;
        q_num = 4'd4;
        for (int c = 0; c < 20; c++) begin
            load = (c == 0 || c == 3 || c == 6 || c == 8 || c == 10 || c == 11 || c == 12);
            in_valid = (c == 0 || c == 6);
            tick();
            exp_v = (c == 10 || c == 13);
            total++;
            if (out_valid !== exp_v || (exp_v && out_num !== 4'd4)) begin
                bad++;
                $display("FAIL gaps c=%0d: got v=%0b n=%0d want v=%0b n=4",
                         c, out_valid, out_num, exp_v);
            end
        end
        load = 1'b0;
        in_valid = 1'b0;
        q_num = '0;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            load = 1'b1;
            in_valid = (c < 3);
            q_num = (c >= 4) ? 4'(c - 3) : 4'd0;
            tick();
            if (c == 5) begin
                total++;
                if (ovf !== 1'b0 || out_valid !== 1'b1 || out_num !== 4'd1) begin
                    bad++;
                    $display("FAIL bp_fill: got ovf=%0b v=%0b n=%0d want ovf=0 v=1 n=1",
                             ovf, out_valid, out_num);
                end
            end
        end
        load = 1'b0;
        in_valid = 1'b0;
        q_num = '0;
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL bp_ovf: got %0b want 1", ovf);
        end
        tick();
        tick();
        total++;
        if (out_valid !== 1'b1 || out_num !== 4'd1 || out_onehot !== 12'h001) begin
            bad++;
            $display("FAIL bp_hold: got v=%0b n=%0d oh=%0h want v=1 n=1 oh=001",
                     out_valid, out_num, out_onehot);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_num !== 4'd2 || out_onehot !== 12'h002) begin
            bad++;
            $display("FAIL bp_pop2: got v=%0b n=%0d oh=%0h want v=1 n=2 oh=002",
                     out_valid, out_num, out_onehot);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain: got v=%0b ovf=%0b want v=0 ovf=1", out_valid, ovf);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL bp_clr: got ovf=%0b want 0", ovf);
        end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            load = (c <= 5);
            in_valid = (c < 2);
            q_num = (c == 5) ? 4'd13 : 4'd0;
            tick();
            if (c == 3) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("FAIL ill_pre: got err=%0b want 0", err);
                end
            end
            if (c == 5 || c == 6) begin
                total++;
                if (out_valid !== 1'b1 || out_num !== ((c == 5) ? 4'd0 : 4'd13) ||
                    out_onehot !== 12'h000 || err !== 1'b1) begin
                    bad++;
                    $display("FAIL ill c=%0d: got v=%0b n=%0d oh=%0h err=%0b want v=1 n=%0d oh=0 err=1",
                             c, out_valid, out_num, out_onehot, err, (c == 5) ? 0 : 13);
                end
            end
        end
        load = 1'b0;
        in_valid = 1'b0;
        q_num = '0;
        total++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ill_sticky: got err=%0b v=%0b want err=1 v=0", err, out_valid);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL ill_clr: got err=%0b want 0", err);
        end
    endtask

    task automatic test_flush;
        int seen = 0;
        out_ready = 1'b1;
        q_num = 4'd5;
        for (int c = 0; c < 14; c++) begin
            load = (c <= 10);
            in_valid = (c <= 2);
            clr = (c == 2);
            tick();
            if (out_valid === 1'b1) seen++;
        end
        clr = 1'b0;
        load = 1'b0;
        in_valid = 1'b0;
        q_num = '0;
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL flush: got %0d results want 0", seen);
        end
    endtask

    task automatic push_class(input int n, input logic [3:0] cls);
        out_ready = 1'b1;
        for (int c = 0; c <= n + 3; c++) begin
            load = (c <= n + 2);
            in_valid = (c < n);
            q_num = (c >= 4) ? cls : 4'd0;
            tick();
        end
        load = 1'b0;
        in_valid = 1'b0;
        q_num = '0;
        repeat (3) tick();
    endtask

    task automatic test_hist;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        hist_sel = 4'd3;
        push_class(5, 4'd3);
        push_class(2, 4'd6);
        tick();
`ifdef CLASS_HIST_EN
        total++;
        if (hist_cnt !== 3'd5) begin
            bad++;
            $display("FAIL hist5: got %0d want 5", hist_cnt);
        end
        hist_sel = 4'd6;
        tick();
        total++;
        if (hist_cnt !== 3'd2) begin
            bad++;
            $display("FAIL hist_sel6: got %0d want 2", hist_cnt);
        end
        hist_sel = 4'd0;
        tick();
        total++;
        if (hist_cnt !== 3'd0) begin
            bad++;
            $display("FAIL hist_sel0: got %0d want 0", hist_cnt);
        end
        hist_sel = 4'd3;
        push_class(4, 4'd3);
        tick();
        total++;
        if (hist_cnt !== 3'd7) begin
            bad++;
            $display("FAIL hist_sat: got %0d want 7", hist_cnt);
        end
`else
        total++;
        if (hist_cnt !== '0) begin
            bad++;
            $display("FAIL hist_off: got %0d want 0", hist_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_gaps();
        test_backpressure();
        test_illegal();
        test_flush();
        test_hist();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
